// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - capture block, frame buffer read port and byte TX bundle
interface capture_sequencer_if #(
    parameter int BUFF_BITS = 16
) ();
    logic                 start_capture;
    logic                 frame_captured;
    logic [BUFF_BITS-1:0] buff_rd_addr;
    logic [7:0]           buff_rd_data;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;

    modport master (
        output start_capture,
        output buff_rd_addr,
        output tx_data,
        output tx_start,
        input  frame_captured,
        input  buff_rd_data,
        input  tx_busy
    );

    modport slave (
        input  start_capture,
        input  buff_rd_addr,
        input  tx_data,
        input  tx_start,
        output frame_captured,
        output buff_rd_data,
        output tx_busy
    );
endinterface

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - sequences frame capture, buffer readout and byte transmission
module capture_sequencer #(
    parameter int TOTAL_BYTES    = 19200,
    parameter int BUFF_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                snap,
    input  logic                continuous,
    capture_sequencer_if.master cap,
    output logic                busy,
    output logic                timeout_err,
    output logic [7:0]          frames_sent
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]        TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BUFF_BITS-1:0] LAST_ADDR = BUFF_BITS'(TOTAL_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        CAPTURE,
        RD_ADDR,
        RD_WAIT,
        TX_REQ,
        TX_HOLD,
        TX_WAIT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 snap_q;
    logic                 snap_edge;
    logic [TW-1:0]        to_cnt;
    logic                 timeout_hit;
    logic [BUFF_BITS-1:0] rd_addr;
    logic [7:0]           tx_data_q;
    logic                 last_byte;

    assign snap_edge   = snap & ~snap_q;
    assign timeout_hit = (to_cnt == TO_LAST);
    assign last_byte   = (rd_addr == LAST_ADDR);

    assign busy             = (state != IDLE);
    assign cap.buff_rd_addr = rd_addr;
    assign cap.tx_data      = tx_data_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the capture enable and the single-cycle TX strobe
    always_comb begin
        state_next        = state;
        cap.start_capture = 1'b0;
        cap.tx_start      = 1'b0;
        case (state)
            IDLE: begin
                if (snap_edge) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                // One low cycle so the capture block clears its write address
                state_next = CAPTURE;
            end
            CAPTURE: begin
                cap.start_capture = 1'b1;
                if (cap.frame_captured) begin
                    state_next = RD_ADDR;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            RD_ADDR: begin
                cap.start_capture = 1'b1;
                state_next        = RD_WAIT;
            end
            RD_WAIT: begin
                cap.start_capture = 1'b1;
                state_next        = TX_REQ;
            end
            TX_REQ: begin
                cap.start_capture = 1'b1;
                if (!cap.tx_busy) begin
                    cap.tx_start = 1'b1;
                    state_next   = TX_HOLD;
                end
            end
            TX_HOLD: begin
                cap.start_capture = 1'b1;
                state_next        = TX_WAIT;
            end
            TX_WAIT: begin
                cap.start_capture = 1'b1;
                if (!cap.tx_busy) begin
                    state_next = last_byte ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                state_next = continuous ? ARM : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: snap edge history, capture timeout, read address, TX byte latch, status
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q      <= 1'b0;
            to_cnt      <= '0;
            rd_addr     <= '0;
            tx_data_q   <= 8'h00;
            timeout_err <= 1'b0;
            frames_sent <= 8'h00;
        end else begin
            snap_q <= snap;

            // Counter only lives while CAPTURE persists; any exit clears it
            if (state == CAPTURE && state_next == CAPTURE) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end

            if (state == CAPTURE && cap.frame_captured) begin
                rd_addr <= '0;
            end else if (state == TX_WAIT && !cap.tx_busy && !last_byte) begin
                rd_addr <= rd_addr + BUFF_BITS'(1);
            end

            if (state == RD_WAIT) begin
                tx_data_q <= cap.buff_rd_data;
            end

            if (state == IDLE && snap_edge) begin
                timeout_err <= 1'b0;
            end else if (state == CAPTURE && !cap.frame_captured && timeout_hit) begin
                timeout_err <= 1'b1;
            end

            if (state == DONE) begin
                frames_sent <= frames_sent + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - scoreboard bench for capture_sequencer
module tb_capture_sequencer;
    localparam int TB = 4;
    localparam int BB = 16;
    localparam int TO = 50;

    typedef struct {
        int       addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       snap;
    logic       continuous;
    logic       busy;
    logic       timeout_err;
    logic [7:0] frames_sent;

    always #5 clk = ~clk;

    capture_sequencer_if #(.BUFF_BITS(BB)) sif ();

    capture_sequencer #(
        .TOTAL_BYTES   (TB),
        .BUFF_BITS     (BB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .snap       (snap),
        .continuous (continuous),
        .cap        (sif),
        .busy       (busy),
        .timeout_err(timeout_err),
        .frames_sent(frames_sent)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] mem [TB];
    int         tx_len [TB];
    int         busy_cnt = 0;
    int         fc_delay = 10;
    bit         fc_enable = 1'b1;
    int         tx_pulses = 0;
    int         low_run = 0;
    int         last_gap = 0;
    exp_t       exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Synchronous-read frame buffer: data follows the address one clock later
    initial begin
        sif.buff_rd_data = 8'h00;
        forever begin
            @(posedge clk);
            sif.buff_rd_data <= (int'(sif.buff_rd_addr) < TB) ? mem[sif.buff_rd_addr] : 8'hEE;
        end
    end

    // Byte transmitter: busy rises the clock after tx_start, lasts tx_len[addr] clocks
    assign sif.tx_busy = (busy_cnt != 0);
    initial begin
        forever begin
            @(posedge clk);
            if (sif.tx_start)
                busy_cnt <= (int'(sif.buff_rd_addr) < TB) ? tx_len[sif.buff_rd_addr] : 1;
            else if (busy_cnt > 0)
                busy_cnt <= busy_cnt - 1;
        end
    end

    // Capture block: pulses frame_captured on the fc_delay-th clock of start_capture
    initial begin
        int cap_cnt;
        cap_cnt = 0;
        sif.frame_captured = 1'b0;
        forever begin
            @(negedge clk);
            sif.frame_captured = 1'b0;
            if (sif.start_capture) begin
                if (fc_enable && cap_cnt == fc_delay - 1) sif.frame_captured = 1'b1;
                cap_cnt++;
            end else begin
                cap_cnt = 0;
            end
        end
    end

    // Monitor: every tx_start is matched against the next expected byte
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sif.tx_start) begin
                tx_pulses++;
                check("tx_start_while_busy", sif.tx_busy, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx: got byte %0h at addr %0d, expected none",
                             sif.tx_data, sif.buff_rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_addr", sif.buff_rd_addr, e.addr);
                    check("tx_data", sif.tx_data, e.data);
                end
            end
            if (busy && !sif.start_capture) begin
                low_run++;
            end else begin
                if (sif.start_capture && low_run > 0) last_gap = low_run;
                low_run = 0;
            end
        end else begin
            low_run = 0;
        end
    end

    task automatic load_frame(input int max_len);
        for (int i = 0; i < TB; i++) begin
            mem[i]    = 8'($urandom);
            tx_len[i] = $urandom_range(1, max_len);
        end
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < TB; i++) begin
            e.addr = i;
            e.data = mem[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_snap();
        @(negedge clk);
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) bound_fail("wait_idle");
    endtask

    task automatic wait_tx(input int target, input int limit);
        int n;
        n = 0;
        while (tx_pulses < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (tx_pulses < target) bound_fail("wait_tx");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int exp_frames;

        rst = 1'b1;
        snap = 1'b0;
        continuous = 1'b0;
        for (int i = 0; i < TB; i++) begin
            mem[i] = 8'h00;
            tx_len[i] = 1;
        end
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_start_capture", sif.start_capture, 0);
        check("rst_buff_rd_addr", sif.buff_rd_addr, 0);
        check("rst_tx_data", sif.tx_data, 0);
        check("rst_tx_start", sif.tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_frames_sent", frames_sent, 0);
        rst = 1'b0;
        exp_frames = 0;

        // Single frame with fixed bytes, slow transmitter
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        for (int i = 0; i < TB; i++) tx_len[i] = 8;
        fc_delay = 10;
        push_frame();
        pulse_snap();
        wait_idle(500);
        exp_frames++;
        check("t1_frames_sent", frames_sent, exp_frames);
        check("t1_start_capture", sif.start_capture, 0);
        check("t1_queue_left", exp_q.size(), 0);
        check("t1_arm_gap", last_gap, 1);

        // Capture timeout, then a fresh snap clears the flag
        fc_enable = 1'b0;
        pulse_snap();
        n = 0;
        while (!sif.start_capture && n < 10) begin @(negedge clk); n++; end
        if (!sif.start_capture) bound_fail("t2_capture_start");
        n = 0;
        while (sif.start_capture && n < 200) begin @(negedge clk); n++; end
        check("t2_capture_cycles", n, TO);
        check("t2_timeout_err", timeout_err, 1);
        check("t2_busy", busy, 0);
        check("t2_frames_sent", frames_sent, exp_frames);
        fc_enable = 1'b1;
        fc_delay = $urandom_range(1, 20);
        load_frame(4);
        push_frame();
        pulse_snap();
        check("t2_timeout_cleared", timeout_err, 0);
        wait_idle(500);
        exp_frames++;
        check("t2_frames_after", frames_sent, exp_frames);
        check("t2_queue_left", exp_q.size(), 0);

        // frame_captured on the same clock as the timeout wins
        fc_delay = TO;
        load_frame(3);
        push_frame();
        pulse_snap();
        wait_idle(500);
        exp_frames++;
        check("t2b_timeout_err", timeout_err, 0);
        check("t2b_frames_sent", frames_sent, exp_frames);
        check("t2b_queue_left", exp_q.size(), 0);

        // Continuous mode, two back-to-back frames
        continuous = 1'b1;
        fc_delay = $urandom_range(1, 15);
        load_frame(5);
        push_frame();
        push_frame();
        base = tx_pulses;
        pulse_snap();
        n = 0;
        while (frames_sent != 8'(exp_frames + 1) && n < 1000) begin @(negedge clk); n++; end
        if (frames_sent != 8'(exp_frames + 1)) bound_fail("t3_first_frame");
        continuous = 1'b0;
        n = 0;
        while (!sif.start_capture && n < 10) begin @(negedge clk); n++; end
        if (!sif.start_capture) bound_fail("t3_rearm");
        @(negedge clk);
        check("t3_rearm_low_cycles", last_gap, 2);
        wait_idle(1000);
        exp_frames += 2;
        check("t3_frames_sent", frames_sent, exp_frames);
        check("t3_tx_pulses", tx_pulses - base, 2 * TB);
        check("t3_queue_left", exp_q.size(), 0);

        // Transmitter stalls 30 clocks on the second byte
        fc_delay = 5;
        load_frame(4);
        tx_len[1] = 30;
        push_frame();
        pulse_snap();
        wait_idle(1000);
        exp_frames++;
        check("t4_frames_sent", frames_sent, exp_frames);
        check("t4_queue_left", exp_q.size(), 0);

        // Reset in the TX_WAIT of the third byte
        load_frame(1);
        for (int i = 0; i < TB; i++) tx_len[i] = 8;
        push_frame();
        base = tx_pulses;
        pulse_snap();
        wait_tx(base + 3, 500);
        repeat (2) @(negedge clk);
        check("t5_in_tx_wait", sif.tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_start_capture", sif.start_capture, 0);
        check("t5_buff_rd_addr", sif.buff_rd_addr, 0);
        check("t5_tx_data", sif.tx_data, 0);
        check("t5_tx_start", sif.tx_start, 0);
        check("t5_busy", busy, 0);
        check("t5_timeout_err", timeout_err, 0);
        check("t5_frames_sent", frames_sent, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        n = 0;
        while (sif.tx_busy && n < 20) begin @(negedge clk); n++; end
        load_frame(2);
        push_frame();
        pulse_snap();
        wait_idle(500);
        exp_frames++;
        check("t5_restart_frames", frames_sent, exp_frames);
        check("t5_restart_queue", exp_q.size(), 0);

        // snap held high for 100 clocks gives one frame
        fc_delay = 10;
        load_frame(2);
        push_frame();
        @(negedge clk);
        snap = 1'b1;
        repeat (100) @(negedge clk);
        snap = 1'b0;
        wait_idle(500);
        repeat (10) @(negedge clk);
        exp_frames++;
        check("t6_held_frames", frames_sent, exp_frames);
        check("t6_held_busy", busy, 0);
        check("t6_held_queue", exp_q.size(), 0);

        // snap pulsed during readout is ignored
        load_frame(3);
        push_frame();
        base = tx_pulses;
        pulse_snap();
        wait_tx(base + 1, 200);
        pulse_snap();
        wait_idle(500);
        repeat (20) @(negedge clk);
        exp_frames++;
        check("t6_pulse_frames", frames_sent, exp_frames);
        check("t6_pulse_busy", busy, 0);
        check("t6_pulse_queue", exp_q.size(), 0);

        // Randomized frames
        for (int k = 0; k < 4; k++) begin
            fc_delay = $urandom_range(1, TO);
            load_frame(6);
            push_frame();
            pulse_snap();
            wait_idle(1000);
            exp_frames++;
            check("t7_frames_sent", frames_sent, exp_frames);
            check("t7_timeout_err", timeout_err, 0);
            check("t7_queue_left", exp_q.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
